// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus bundle between the CPU and the memory-mapped UART transmitter.
// The CPU drives address, data and strobes; the UART returns status data, decode hit and stall.
interface uart_tx_mmio_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memwrite;
    logic        memread;
    logic [31:0] rdata;
    logic        hit;
    logic        stall;

    modport master (
        output addr, wdata, memwrite, memread,
        input  rdata, hit, stall
    );

    modport slave (
        input  addr, wdata, memwrite, memread,
        output rdata, hit, stall
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: stores to TX_ADDR fill a byte FIFO that an 8N1/8N2
// serializer drains; a full FIFO stalls the store, and STATUS_ADDR reports level and idle.
module uart_tx_mmio #(
    parameter int          BAUD_DIV    = 104,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          STOP_BITS   = 1,
    parameter logic [31:0] TX_ADDR     = 32'h2001,
    parameter logic [31:0] STATUS_ADDR = 32'h2002
) (
    input  logic           clk,
    input  logic           rstn,
    uart_tx_mmio_if.slave  bus,
    output logic           tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [7:0]    shift_reg, shift_next;
    logic [BW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic          stop_reg, stop_next;
    logic          tx_reg, tx_next;
    logic          sel_tx, sel_status;
    logic          full, empty, idle;
    logic          push, pop, flush;
    logic          baud_end, stop_last;
    logic [7:0]    count_byte;
    logic          unused_wdata;

    assign sel_tx     = (bus.addr == TX_ADDR);
    assign sel_status = (bus.addr == STATUS_ADDR);
    assign full       = (count_reg == FULL_COUNT);
    assign empty      = (count_reg == '0);
    assign idle       = empty && (state_reg == IDLE);

    assign push  = bus.memwrite && sel_tx && !full;
    assign flush = bus.memwrite && sel_status && bus.wdata[0];

    assign bus.stall = bus.memwrite && sel_tx && full;
    assign bus.hit   = (sel_tx || sel_status) && (bus.memwrite || bus.memread);

    // Zero-extend count into the status byte regardless of FIFO_DEPTH.
    for (genvar gi = 0; gi < 8; gi++) begin : g_count_byte
        if (gi < CW) begin : g_bit
            assign count_byte[gi] = count_reg[gi];
        end else begin : g_zero
            assign count_byte[gi] = 1'b0;
        end
    end

    assign bus.rdata = (bus.memread && sel_status)
                     ? {16'h0000, count_byte, 5'b00000, empty, full, idle}
                     : 32'h0000_0000;

    assign unused_wdata = ^bus.wdata[31:8];

    assign baud_end  = (baud_reg == BAUD_LAST);
    assign stop_last = (STOP_BITS == 1) || stop_reg;

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        stop_next  = stop_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                // A same-cycle flush wins, so no frame starts from a discarded entry.
                if (!empty && !flush) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr_reg];
                    baud_next  = '0;
                    state_next = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_next  = '0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        stop_next  = 1'b0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (!stop_last) begin
                        stop_next = 1'b1;
                    end else if (!empty && !flush) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr_reg];
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // The line is registered from the next state, so a pop drives the start bit on the same edge.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            shift_reg  <= '0;
            baud_reg   <= '0;
            bit_reg    <= '0;
            stop_reg   <= 1'b0;
            tx_reg     <= 1'b1;
        end else begin
            state_reg  <= state_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            shift_reg  <= shift_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            stop_reg   <= stop_next;
            tx_reg     <= tx_next;
        end
    end

    assign tx = tx_reg;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: stores are pushed to a byte scoreboard, and a line
// receiver decodes tx frames and pops/compares them; status and stall are checked inline.
module tb_uart_tx_mmio;
    localparam int          BD     = 4;
    localparam int          FD     = 4;
    localparam logic [31:0] TXA    = 32'h2001;
    localparam logic [31:0] STA    = 32'h2002;
    localparam int          FRAME  = 10 * BD;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic tx;

    uart_tx_mmio_if bus_if();

    uart_tx_mmio #(
        .BAUD_DIV(BD), .FIFO_DEPTH(FD), .STOP_BITS(1),
        .TX_ADDR(TXA), .STATUS_ADDR(STA)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus_if),
        .tx(tx)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    int cyc = 0;
    int frames = 0;
    int contig = 0;
    int last_start = -1000;
    int max_count = 0;

    logic [31:0] r;
    logic        h;
    int          w;
    int          frames0, contig0;
    logic [7:0]  byte_v, head_v;
    logic        e;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (int'(dut.count_reg) > max_count) max_count = int'(dut.count_reg);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- line receiver / scoreboard consumer ----------------
    task automatic mon_wait(input int n, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rstn) aborted = 1'b1;
        end
    endtask

    task automatic rx_frame();
        int c0;
        bit ab;
        logic [7:0] b;
        c0 = cyc;
        b = 8'h00;
        mon_wait(2, ab);
        if (ab) return;
        chk("rx_start_bit", 32'(tx), 32'd0);
        for (int j = 0; j < 8; j++) begin
            mon_wait(BD, ab);
            if (ab) return;
            b[j] = tx;
        end
        mon_wait(BD, ab);
        if (ab) return;
        chk("rx_stop_bit", 32'(tx), 32'd1);
        total++;
        assert (exp_q.size() > 0) else begin
            bad++;
            $error("FAIL rx_unexpected_frame observed=%h expected=none", b);
        end
        if (exp_q.size() > 0) chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
        $display("rx frame byte=%h start_cycle=%0d", b, c0);
        if (c0 - last_start == FRAME) contig++;
        last_start = c0;
        frames++;
        mon_wait(1, ab);
    endtask

    initial begin : receiver
        forever begin
            @(negedge clk);
            if (rstn && tx === 1'b0) rx_frame();
        end
    end

    // ---------------- bus driver tasks ----------------
    task automatic bus_idle();
        @(negedge clk);
        bus_if.memwrite = 1'b0;
        bus_if.memread  = 1'b0;
        bus_if.addr     = 32'h0;
        bus_if.wdata    = 32'h0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, output int waits);
        @(negedge clk);
        bus_if.addr     = a;
        bus_if.wdata    = d;
        bus_if.memwrite = 1'b1;
        bus_if.memread  = 1'b0;
        #1;
        waits = 0;
        while (bus_if.stall === 1'b1 && waits < 2000) begin
            waits++;
            @(negedge clk);
            #1;
        end
        if (waits >= 2000) chk("store_stall_timeout", 32'(waits), 32'd0);
        @(posedge clk);
        if (a == TXA) exp_q.push_back(d[7:0]);
        $display("store addr=%h data=%h stall_cycles=%0d", a, d, waits);
    endtask

    task automatic read_bus(input logic [31:0] a, input logic rd, output logic [31:0] rv, output logic hv);
        @(negedge clk);
        bus_if.addr     = a;
        bus_if.memread  = rd;
        bus_if.memwrite = 1'b0;
        #1;
        rv = bus_if.rdata;
        hv = bus_if.hit;
        bus_if.memread = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] rv;
        logic        hv;
        int n;
        n = 0;
        rv = 32'h0;
        while (n < 2000) begin
            read_bus(STA, 1'b1, rv, hv);
            if (rv == 32'h5 && exp_q.size() == 0) break;
            n++;
        end
        chk(tag, rv, 32'h5);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench time limit reached");
    end

    // ---------------- directed sequence ----------------
    initial begin : stimulus
        bus_if.addr = 32'h0; bus_if.wdata = 32'h0;
        bus_if.memwrite = 1'b0; bus_if.memread = 1'b0;

        // Reset and idle
        repeat (3) @(negedge clk);
        #1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_stall", 32'(bus_if.stall), 32'd0);
        chk("reset_hit", 32'(bus_if.hit), 32'd0);
        rstn = 1'b1;
        read_bus(STA, 1'b1, r, h);
        chk("reset_status", r, 32'h5);
        chk("status_hit", 32'(h), 32'd1);
        read_bus(32'h2003, 1'b1, r, h);
        chk("other_addr_rdata", r, 32'h0);
        chk("other_addr_hit", 32'(h), 32'd0);
        read_bus(STA, 1'b0, r, h);
        chk("no_read_rdata", r, 32'h0);
        chk("no_read_hit", 32'(h), 32'd0);

        // Single byte waveform, cycle by cycle
        byte_v = 8'hA5;
        store(TXA, 32'(byte_v), w);
        bus_idle();
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i / BD == 0)      e = 1'b0;
            else if (i / BD <= 8) e = byte_v[i / BD - 1];
            else                  e = 1'b1;
            chk($sformatf("single_tx_c%0d", i), 32'(tx), 32'(e));
        end
        repeat (2) @(negedge clk);
        wait_idle("single_status");

        // Back-to-back stores into a 4-deep FIFO, then a stalled 6th store
        frames0 = frames;
        contig0 = contig;
        for (int i = 0; i < 5; i++) store(TXA, 32'h10 + 32'(i), w);
        read_bus(STA, 1'b1, r, h);
        chk("full_status", r, 32'h0000_0402);
        store(TXA, 32'h15, w);
        chk("full_stall_cycles", 32'(w), 32'd36);
        bus_idle();
        wait_idle("b2b_status");
        chk("b2b_frames", 32'(frames - frames0), 32'd6);
        chk("b2b_contiguous", 32'(contig - contig0), 32'd5);

        // Wrap-around: 3*FIFO_DEPTH bytes
        frames0 = frames;
        @(negedge clk);
        max_count = 0;
        for (int i = 0; i < 3 * FD; i++) store(TXA, 32'(i), w);
        bus_idle();
        wait_idle("wrap_status");
        chk("wrap_frames", 32'(frames - frames0), 32'(3 * FD));
        chk("wrap_max_count", 32'(max_count), 32'(FD));

        // Flush with 3 bytes queued behind an active frame
        frames0 = frames;
        store(TXA, 32'h3C, w);
        store(TXA, 32'hC3, w);
        store(TXA, 32'h5A, w);
        store(TXA, 32'h96, w);
        bus_idle();
        repeat (4) @(negedge clk);
        read_bus(STA, 1'b1, r, h);
        chk("flush_pre_status", r, 32'h0000_0300);
        store(STA, 32'h1, w);
        head_v = exp_q[0];
        exp_q.delete();
        exp_q.push_back(head_v);
        bus_idle();
        read_bus(STA, 1'b1, r, h);
        chk("flush_busy_status", r, 32'h4);
        wait_idle("flush_status");
        repeat (3 * FRAME) @(negedge clk);
        chk("flush_frames", 32'(frames - frames0), 32'd1);

        // Reset in the middle of a data bit with bytes still queued
        frames0 = frames;
        store(TXA, 32'hF0, w);
        store(TXA, 32'h0F, w);
        store(TXA, 32'h55, w);
        bus_idle();
        repeat (12) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("reset_mid_tx", 32'(tx), 32'd1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        read_bus(STA, 1'b1, r, h);
        chk("reset_mid_status", r, 32'h5);
        repeat (3 * FRAME) @(negedge clk);
        chk("reset_mid_frames", 32'(frames - frames0), 32'd0);
        read_bus(STA, 1'b1, r, h);
        chk("reset_mid_status_late", r, 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
